lpc_host: RTL and testbench

//  LPC 1.1 host-side cycle generator: the initiator that drives lpc_frame/lpc_ad to run
//  I/O and memory read/write cycles, for bench and board bring-up of the sniffer and target.

---
 rtl/lpc_host.sv | 190 +++++++++++++++++++
 tb/tb_lpc_host.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_host.sv
// LPC 1.1 host cycle generator: serialises one I/O or memory request onto lpc_frame/lpc_ad,
// waits on target SYNC (with timeout abort) and returns status on a one-cycle strobe.
module lpc_host #(
   parameter int SYNC_TIMEOUT = 8
) (
   input  logic        lpc_clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_cyctype_dir,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_data,
   output logic        lpc_frame,
   output logic [3:0]  lpc_ad_out,
   output logic        lpc_ad_oe,
   input  logic [3:0]  lpc_ad_in,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_error,
   output logic        rsp_timeout
);
   typedef enum logic [3:0] {
      IDLE, START, CYCTYPE, ADDR, WDATA, TAR_H, SYNC, RDATA, TAR_P, ABORT, RESP
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  cyc_q, cyc_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d, rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        rsp_error_q, rsp_error_d, rsp_timeout_q, rsp_timeout_d;
   logic        frame_q, frame_d, oe_q, oe_d, rsp_valid_q, rsp_valid_d, req_ready_q, req_ready_d;
   logic [3:0]  ad_q, ad_d;
   logic [7:0]  addr_last;
   logic [2:0]  nib;

   // cyc bit2 selects memory (8 address nibbles), bit1 selects write
   assign addr_last = cyc_q[2] ? 8'd7 : 8'd3;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cyc_d         = cyc_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      rsp_data_d    = rsp_data_q;
      rsp_error_d   = rsp_error_q;
      rsp_timeout_d = rsp_timeout_q;
      case (state_q)
         IDLE: if (req_valid) begin
            cyc_d   = req_cyctype_dir;
            addr_d  = req_addr;
            wdata_d = req_data;
            err_d   = 1'b0;
            if (req_cyctype_dir[3] || req_cyctype_dir[0]) begin
               state_d       = RESP;
               rsp_data_d    = 8'h00;
               rsp_error_d   = 1'b1;
               rsp_timeout_d = 1'b0;
            end else begin
               state_d = START;
            end
         end
         START:   state_d = CYCTYPE;
         CYCTYPE: begin state_d = ADDR; cnt_d = 8'd0; end
         ADDR: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == addr_last) begin
               state_d = cyc_q[1] ? WDATA : TAR_H;
               cnt_d   = 8'd0;
            end
         end
         WDATA: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd1) begin state_d = TAR_H; cnt_d = 8'd0; end
         end
         TAR_H: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd1) begin state_d = SYNC; cnt_d = 8'd0; end
         end
         SYNC: begin
            if (lpc_ad_in == 4'b0000 || lpc_ad_in == 4'b1010) begin
               err_d   = (lpc_ad_in == 4'b1010);
               state_d = cyc_q[1] ? TAR_P : RDATA;
               cnt_d   = 8'd0;
            end else if (cnt_q == 8'(SYNC_TIMEOUT - 1)) begin
               state_d = ABORT;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RDATA: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd0) rdata_d[3:0] = lpc_ad_in;
            else begin
               rdata_d[7:4] = lpc_ad_in;
               state_d      = TAR_P;
               cnt_d        = 8'd0;
            end
         end
         TAR_P: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd1) begin
               state_d       = RESP;
               rsp_data_d    = cyc_q[1] ? 8'h00 : rdata_q;
               rsp_error_d   = err_q;
               rsp_timeout_d = 1'b0;
            end
         end
         ABORT: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd4) begin
               state_d       = RESP;
               rsp_data_d    = 8'hFF;
               rsp_error_d   = 1'b0;
               rsp_timeout_d = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Bus drive is decoded from the next state so it lines up with the state register
      frame_d = 1'b1;
      ad_d    = 4'hF;
      oe_d    = 1'b0;
      nib     = 3'(addr_last - cnt_d);
      case (state_d)
         START:   begin frame_d = 1'b0; ad_d = 4'h0; oe_d = 1'b1; end
         CYCTYPE: begin ad_d = cyc_q; oe_d = 1'b1; end
         ADDR:    begin ad_d = addr_q[{nib, 2'b00} +: 4]; oe_d = 1'b1; end
         WDATA:   begin ad_d = cnt_d[0] ? wdata_q[7:4] : wdata_q[3:0]; oe_d = 1'b1; end
         TAR_H:   oe_d = (cnt_d == 8'd0);
         ABORT:   if (cnt_d != 8'd4) begin frame_d = 1'b0; oe_d = 1'b1; end
         default: ;
      endcase
      rsp_valid_d = (state_d == RESP);
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge lpc_clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         cyc_q         <= 4'd0;
         addr_q        <= 32'd0;
         wdata_q       <= 8'd0;
         rdata_q       <= 8'd0;
         err_q         <= 1'b0;
         rsp_data_q    <= 8'd0;
         rsp_error_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
         frame_q       <= 1'b1;
         ad_q          <= 4'hF;
         oe_q          <= 1'b0;
         rsp_valid_q   <= 1'b0;
         req_ready_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cyc_q         <= cyc_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         rdata_q       <= rdata_d;
         err_q         <= err_d;
         rsp_data_q    <= rsp_data_d;
         rsp_error_q   <= rsp_error_d;
         rsp_timeout_q <= rsp_timeout_d;
         frame_q       <= frame_d;
         ad_q          <= ad_d;
         oe_q          <= oe_d;
         rsp_valid_q   <= rsp_valid_d;
         req_ready_q   <= req_ready_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign lpc_frame   = frame_q;
   assign lpc_ad_out  = ad_q;
   assign lpc_ad_oe   = oe_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_lpc_host.sv
// Directed bench for lpc_host: per-cycle bus capture against hand-derived LPC cycle frames.
module tb_lpc_host;
   logic        lpc_clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_cyctype_dir = 4'h0;
   logic [31:0] req_addr = 32'h0;
   logic [7:0]  req_data = 8'h0;
   logic        lpc_frame;
   logic [3:0]  lpc_ad_out;
   logic        lpc_ad_oe;
   logic [3:0]  lpc_ad_in = 4'hF;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_error;
   logic        rsp_timeout;

   int n_chk = 0;
   int n_fail = 0;

   logic [3:0] scr  [0:47];
   logic [3:0] ad_a [0:47];
   logic       fr_a [0:47];
   logic       oe_a [0:47];
   logic       rv_a [0:47];
   logic       rr_a [0:47];

   lpc_host #(.SYNC_TIMEOUT(8)) dut (
      .lpc_clock(lpc_clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_cyctype_dir(req_cyctype_dir),
      .req_addr(req_addr), .req_data(req_data),
      .lpc_frame(lpc_frame), .lpc_ad_out(lpc_ad_out), .lpc_ad_oe(lpc_ad_oe), .lpc_ad_in(lpc_ad_in),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout)
   );

   always #5 lpc_clock = ~lpc_clock;

   task automatic clear_scr();
      for (int i = 0; i < 48; i++) scr[i] = 4'hF;
   endtask

   // Cycle k=1 is the first cycle after the acceptance edge; target AD for cycle k comes from scr[k]
   task automatic run(input int n);
      for (int k = 1; k <= n; k++) begin
         lpc_ad_in = scr[k];
         ad_a[k] = lpc_ad_out; fr_a[k] = lpc_frame; oe_a[k] = lpc_ad_oe;
         rv_a[k] = rsp_valid;  rr_a[k] = req_ready;
         @(posedge lpc_clock); #1;
      end
      lpc_ad_in = 4'hF;
   endtask

   task automatic issue(input logic [3:0] cyc, input logic [31:0] addr, input logic [7:0] data);
      n_chk++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready got %b want 1", req_ready); end
      req_valid = 1'b1; req_cyctype_dir = cyc; req_addr = addr; req_data = data;
      @(posedge lpc_clock); #1;
      req_valid = 1'b0; req_cyctype_dir = 4'hC; req_addr = 32'hDEAD_BEEF; req_data = 8'h77;
   endtask

   task automatic test_reset();
      n_chk++;
      if ({lpc_frame, lpc_ad_out, lpc_ad_oe, rsp_valid, rsp_data, rsp_error, rsp_timeout, req_ready}
          !== {1'b1, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_state got fr=%b ad=%h oe=%b rv=%b rd=%h re=%b rt=%b rr=%b", lpc_frame,
                  lpc_ad_out, lpc_ad_oe, rsp_valid, rsp_data, rsp_error, rsp_timeout, req_ready);
      end
   endtask

   task automatic test_io_write();
      logic [35:0] exp = 36'h0_2_0_0_8_0_5_A_F;
      clear_scr(); scr[11] = 4'h0;
      issue(4'b0010, 32'h0000_0080, 8'hA5);
      run(16);
      for (int k = 1; k <= 9; k++) begin
         n_chk++;
         if (ad_a[k] !== exp[(9-k)*4 +: 4] || oe_a[k] !== 1'b1) begin
            n_fail++; $display("FAIL iow_ad k=%0d got %h/%b want %h/1", k, ad_a[k], oe_a[k], exp[(9-k)*4 +: 4]);
         end
      end
      for (int k = 10; k <= 14; k++) begin
         n_chk++;
         if (oe_a[k] !== 1'b0) begin n_fail++; $display("FAIL iow_oe k=%0d got %b want 0", k, oe_a[k]); end
      end
      for (int k = 1; k <= 16; k++) begin
         n_chk++;
         if (fr_a[k] !== (k != 1) || rv_a[k] !== (k == 14)) begin
            n_fail++; $display("FAIL iow_frame_rv k=%0d got %b/%b want %b/%b", k, fr_a[k], rv_a[k], k != 1, k == 14);
         end
      end
      n_chk++;
      if (rr_a[14] !== 1'b0 || rr_a[15] !== 1'b1) begin
         n_fail++; $display("FAIL iow_ready got %b%b want 01", rr_a[14], rr_a[15]);
      end
      n_chk++;
      if ({rsp_data, rsp_error, rsp_timeout} !== {8'h00, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL iow_rsp got %h %b %b want 00 0 0", rsp_data, rsp_error, rsp_timeout);
      end
   endtask

   task automatic test_mem_read();
      logic [43:0] exp = 44'h0_4_F_F_F_F_F_F_F_0_F;
      clear_scr(); scr[13] = 4'h0; scr[14] = 4'h3; scr[15] = 4'hC;
      issue(4'b0100, 32'hFFFF_FFF0, 8'h00);
      run(20);
      for (int k = 1; k <= 11; k++) begin
         n_chk++;
         if (ad_a[k] !== exp[(11-k)*4 +: 4] || oe_a[k] !== 1'b1) begin
            n_fail++; $display("FAIL mrd_ad k=%0d got %h/%b want %h/1", k, ad_a[k], oe_a[k], exp[(11-k)*4 +: 4]);
         end
      end
      for (int k = 12; k <= 20; k++) begin
         n_chk++;
         if (oe_a[k] !== 1'b0 || fr_a[k] !== 1'b1 || rv_a[k] !== (k == 18)) begin
            n_fail++; $display("FAIL mrd_tail k=%0d got oe=%b fr=%b rv=%b want 0 1 %b", k, oe_a[k], fr_a[k], rv_a[k], k == 18);
         end
      end
      n_chk++;
      if ({rsp_data, rsp_error, rsp_timeout} !== {8'hC3, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL mrd_rsp got %h %b %b want c3 0 0", rsp_data, rsp_error, rsp_timeout);
      end
   endtask

   task automatic test_unsupported();
      logic [3:0] cycs [0:1];
      cycs[0] = 4'b1000; cycs[1] = 4'b0011;
      for (int t = 0; t < 2; t++) begin
         clear_scr();
         issue(cycs[t], 32'h0000_0080, 8'h11);
         run(4);
         for (int k = 1; k <= 4; k++) begin
            n_chk++;
            if (fr_a[k] !== 1'b1 || oe_a[k] !== 1'b0 || rv_a[k] !== (k == 1)) begin
               n_fail++; $display("FAIL unsup c=%b k=%0d got fr=%b oe=%b rv=%b want 1 0 %b", cycs[t], k, fr_a[k], oe_a[k], rv_a[k], k == 1);
            end
         end
         n_chk++;
         if (rsp_error !== 1'b1 || rsp_timeout !== 1'b0) begin
            n_fail++; $display("FAIL unsup_rsp c=%b got err=%b to=%b want 1 0", cycs[t], rsp_error, rsp_timeout);
         end
      end
   endtask

   task automatic test_io_wait();
      clear_scr(); scr[9] = 4'h6; scr[10] = 4'h6; scr[11] = 4'h6; scr[12] = 4'h0;
      scr[13] = 4'hA; scr[14] = 4'h5;
      issue(4'b0000, 32'h0000_02E8, 8'h00);
      run(20);
      for (int k = 1; k <= 20; k++) begin
         n_chk++;
         if (rv_a[k] !== (k == 17) || (k >= 8 && oe_a[k] !== 1'b0)) begin
            n_fail++; $display("FAIL iowait k=%0d got rv=%b oe=%b want %b", k, rv_a[k], oe_a[k], k == 17);
         end
      end
      n_chk++;
      if ({rsp_data, rsp_error, rsp_timeout} !== {8'h5A, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL iowait_rsp got %h %b %b want 5a 0 0", rsp_data, rsp_error, rsp_timeout);
      end
   endtask

   task automatic test_timeout();
      clear_scr();
      issue(4'b0000, 32'h0000_0060, 8'h00);
      run(24);
      for (int k = 9; k <= 24; k++) begin
         n_chk++;
         if (fr_a[k] !== !(k >= 17 && k <= 20) || oe_a[k] !== (k >= 17 && k <= 20) ||
             rv_a[k] !== (k == 22) || (k >= 17 && k <= 20 && ad_a[k] !== 4'hF)) begin
            n_fail++; $display("FAIL tmo k=%0d got fr=%b oe=%b rv=%b ad=%h", k, fr_a[k], oe_a[k], rv_a[k], ad_a[k]);
         end
      end
      n_chk++;
      if ({rsp_data, rsp_error, rsp_timeout} !== {8'hFF, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL tmo_rsp got %h %b %b want ff 0 1", rsp_data, rsp_error, rsp_timeout);
      end
   endtask

   task automatic test_sync_error();
      logic [39:0] exp = 40'h1_2_3_4_5_6_7_8_C_3;
      clear_scr(); scr[15] = 4'hA;
      issue(4'b0110, 32'h1234_5678, 8'h3C);
      run(20);
      for (int k = 3; k <= 12; k++) begin
         n_chk++;
         if (ad_a[k] !== exp[(12-k)*4 +: 4]) begin
            n_fail++; $display("FAIL mwr_ad k=%0d got %h want %h", k, ad_a[k], exp[(12-k)*4 +: 4]);
         end
      end
      for (int k = 1; k <= 20; k++) begin
         n_chk++;
         if (rv_a[k] !== (k == 18)) begin n_fail++; $display("FAIL mwr_rv k=%0d got %b want %b", k, rv_a[k], k == 18); end
      end
      n_chk++;
      if ({rsp_data, rsp_error, rsp_timeout} !== {8'h00, 1'b1, 1'b0}) begin
         n_fail++; $display("FAIL mwr_rsp got %h %b %b want 00 1 0", rsp_data, rsp_error, rsp_timeout);
      end
   endtask

   task automatic test_reset_mid();
      clear_scr(); scr[11] = 4'h0;
      issue(4'b0010, 32'h0000_0080, 8'hA5);
      run(4);
      n_chk++;
      if (lpc_frame !== 1'b1 || lpc_ad_oe !== 1'b1) begin
         n_fail++; $display("FAIL rmid_pre got fr=%b oe=%b want 1 1", lpc_frame, lpc_ad_oe);
      end
      reset = 1'b1; #1;
      test_reset();
      @(posedge lpc_clock); #1;
      reset = 1'b0;
      clear_scr();
      run(20);
      for (int k = 1; k <= 20; k++) begin
         n_chk++;
         if (rv_a[k] !== 1'b0 || fr_a[k] !== 1'b1) begin
            n_fail++; $display("FAIL rmid_idle k=%0d got rv=%b fr=%b want 0 1", k, rv_a[k], fr_a[k]);
         end
      end
      clear_scr(); scr[9] = 4'h0; scr[10] = 4'h7; scr[11] = 4'hE;
      issue(4'b0000, 32'h0000_0080, 8'h00);
      run(16);
      for (int k = 1; k <= 16; k++) begin
         n_chk++;
         if (rv_a[k] !== (k == 14)) begin n_fail++; $display("FAIL rmid_rv k=%0d got %b want %b", k, rv_a[k], k == 14); end
      end
      n_chk++;
      if ({rsp_data, rsp_error, rsp_timeout} !== {8'hE7, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL rmid_rsp got %h %b %b want e7 0 0", rsp_data, rsp_error, rsp_timeout);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp = 16'h0081;
      clear_scr(); scr[11] = 4'h0;
      req_valid = 1'b1; req_cyctype_dir = 4'b0010; req_addr = 32'h0000_0080; req_data = 8'hA5;
      @(posedge lpc_clock); #1;
      req_cyctype_dir = 4'b0000; req_addr = 32'h0000_0081; req_data = 8'h00;
      run(15);
      req_valid = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         n_chk++;
         if (fr_a[k] !== (k != 1) || rv_a[k] !== (k == 14) || rr_a[k] !== (k == 15)) begin
            n_fail++; $display("FAIL b2b_first k=%0d got fr=%b rv=%b rr=%b", k, fr_a[k], rv_a[k], rr_a[k]);
         end
      end
      clear_scr(); scr[9] = 4'h0; scr[10] = 4'h1; scr[11] = 4'h9;
      run(14);
      n_chk++;
      if (fr_a[1] !== 1'b0 || ad_a[2] !== 4'h0) begin
         n_fail++; $display("FAIL b2b_start got fr=%b cyc=%h want 0 0", fr_a[1], ad_a[2]);
      end
      for (int k = 3; k <= 6; k++) begin
         n_chk++;
         if (ad_a[k] !== exp[(6-k)*4 +: 4]) begin
            n_fail++; $display("FAIL b2b_addr k=%0d got %h want %h", k, ad_a[k], exp[(6-k)*4 +: 4]);
         end
      end
      n_chk++;
      if (rv_a[14] !== 1'b1 || rsp_data !== 8'h91) begin
         n_fail++; $display("FAIL b2b_rsp got rv=%b data=%h want 1 91", rv_a[14], rsp_data);
      end
   endtask

   initial begin
      clear_scr();
      repeat (2) @(posedge lpc_clock);
      #1;
      test_reset();
      reset = 1'b0;
      @(posedge lpc_clock); #1;
      test_io_write();
      test_mem_read();
      test_unsupported();
      test_io_wait();
      test_timeout();
      test_sync_error();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
